// File: rtl/pl0_fetch.sv
// Pipeline stage 0: owns the PC, drives the synchronous instruction memory and
// feeds decode. Optional perf counters are enabled with `define PL0_FETCH_PERF_EN.
module pl0_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_pl0_stall_state_val,
    input  logic        i_br_take,
    input  logic [31:0] i_br_target,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_rd_en,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_pc_val,
    output logic [31:0] o_cur_instr_val,
    output logic        o_instr_valid
`ifdef PL0_FETCH_PERF_EN
    ,
    output logic [31:0] o_stall_cycle_cnt,
    output logic [31:0] o_flush_cnt
`endif
);

    localparam logic [1:0] PL0_RUN = 2'd0;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [31:0] pc_q;
    logic [31:0] pc_out_q;
    logic [31:0] hold_q;
    logic [1:0]  stall_cnt;
    logic        flush_q;
    logic        replay_q;
    logic [0:0]  state;
    logic        stall_req;

    assign state     = (stall_cnt != 2'd0) ? ST_HOLD : ST_RUN;
    assign stall_req = (state == ST_RUN) && (i_pl0_stall_state_val != PL0_RUN);

    // Read enable follows reset directly so the very first edge after release
    // already launches the fetch of RESET_PC.
    assign o_imem_rd_en    = i_rst_n;
    assign o_imem_addr     = pc_q;
    assign o_pc_val        = pc_out_q;
    assign o_instr_valid   = !flush_q;
    assign o_cur_instr_val = flush_q  ? NOP_INSTR :
                             replay_q ? hold_q    : i_imem_data;

    // Redirect beats any stall; a stall request is only honoured in RUN and
    // freezes both PCs, replaying the captured instruction from hold_q.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q      <= RESET_PC;
            pc_out_q  <= RESET_PC;
            hold_q    <= NOP_INSTR;
            stall_cnt <= 2'd0;
            flush_q   <= 1'b1;
            replay_q  <= 1'b0;
        end else begin
            flush_q <= i_br_take;
            if (i_br_take) begin
                pc_q      <= i_br_target & ~32'd3;
                stall_cnt <= 2'd0;
                replay_q  <= 1'b0;
            end else if (state == ST_HOLD) begin
                stall_cnt <= stall_cnt - 2'd1;
            end else if (stall_req) begin
                hold_q    <= o_cur_instr_val;
                replay_q  <= 1'b1;
                stall_cnt <= i_pl0_stall_state_val - 2'd1;
            end else begin
                pc_q     <= pc_q + 32'd4;
                pc_out_q <= pc_q;
                replay_q <= 1'b0;
            end
        end
    end

`ifdef PL0_FETCH_PERF_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cycle_cnt <= 32'd0;
            o_flush_cnt       <= 32'd0;
        end else begin
            if (replay_q) begin
                o_stall_cycle_cnt <= o_stall_cycle_cnt + 32'd1;
            end
            if (i_br_take) begin
                o_flush_cnt <= o_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pl0_fetch.sv
// Bench for pl0_fetch: directed scenarios with literal expectations, then random
// stall/redirect/reset traffic compared every cycle against a transaction-level model.
module tb_pl0_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [1:0]  stall_val;
    logic        br_take;
    logic [31:0] br_target;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_data;
    logic [31:0] pc_val;
    logic [31:0] cur_instr;
    logic        instr_valid;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    pl0_fetch #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .i_pl0_stall_state_val(stall_val),
        .i_br_take            (br_take),
        .i_br_target          (br_target),
        .o_imem_addr          (imem_addr),
        .o_imem_rd_en         (imem_rd_en),
        .i_imem_data          (imem_data),
        .o_pc_val             (pc_val),
        .o_cur_instr_val      (cur_instr),
        .o_instr_valid        (instr_valid)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a;
    endfunction

    // Synchronous instruction memory, one cycle read latency.
    always @(posedge i_clk) begin
        if (imem_rd_en) imem_data <= mem_word(imem_addr);
    end

    // Reference model: tracks the item decode sees (instr, pc, valid), the next
    // fetch address, and how many extra presentations of it are still owed.
    logic [31:0] m_fetch;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    int          m_left;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_fetch = RESET_PC;
            m_pc    = RESET_PC;
            m_instr = NOP_INSTR;
            m_valid = 1'b0;
            m_left  = 0;
        end else if (br_take) begin
            m_fetch = {br_target[31:2], 2'b00};
            m_instr = NOP_INSTR;
            m_valid = 1'b0;
            m_left  = 0;
        end else if (m_left > 0) begin
            m_left  = m_left - 1;
            m_valid = 1'b1;
        end else if (stall_val != 2'd0) begin
            m_left  = int'(stall_val) - 1;
            m_valid = 1'b1;
        end else begin
            m_instr = mem_word(m_fetch);
            m_pc    = m_fetch;
            m_fetch = m_fetch + 32'd4;
            m_valid = 1'b1;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge i_clk) begin
        if (check_en) begin
            cmp("model_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            cmp("model_instr", cur_instr, m_instr);
            cmp("model_pc",    pc_val,    m_pc);
            cmp("model_addr",  imem_addr, m_fetch);
            cmp("model_rd_en", {31'd0, imem_rd_en}, {31'd0, i_rst_n});
        end
    end

    task automatic applyStimulus(input logic [1:0] st, input logic br, input logic [31:0] tgt);
        @(negedge i_clk);
        #1;
        stall_val = st;
        br_take   = br;
        br_target = tgt;
    endtask

    task automatic checkOutput(input string name, input logic v, input logic [31:0] pc,
                               input logic [31:0] instr);
        cmp({name, "_valid"}, {31'd0, instr_valid}, {31'd0, v});
        cmp({name, "_instr"}, cur_instr, instr);
        if (v) cmp({name, "_pc"}, pc_val, pc);
    endtask

    task automatic checkReset(input string name);
        cmp({name, "_addr"},  imem_addr, RESET_PC);
        cmp({name, "_rd_en"}, {31'd0, imem_rd_en}, 32'd0);
        cmp({name, "_pc"},    pc_val, RESET_PC);
        cmp({name, "_instr"}, cur_instr, NOP_INSTR);
        cmp({name, "_valid"}, {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        i_rst_n   = 1'b0;
        stall_val = 2'd0;
        br_take   = 1'b0;
        br_target = 32'd0;
        repeat (3) @(negedge i_clk);
        #1;
        check_en = 1'b1;
        checkReset("reset");
        i_rst_n = 1'b1;
        checkOutput("first_bubble", 1'b0, RESET_PC, NOP_INSTR);

        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("run_0", 1'b1, 32'h0, 32'hFFFF_FFFF);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("run_4", 1'b1, 32'h4, 32'hFFFF_FFFB);
        applyStimulus(2'd0, 1'b0, 32'd0);
        applyStimulus(2'd1, 1'b0, 32'd0);
        checkOutput("pre_stall1", 1'b1, 32'hC, 32'hFFFF_FFF3);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("stall1_replay", 1'b1, 32'hC, 32'hFFFF_FFF3);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("stall1_resume", 1'b1, 32'h10, 32'hFFFF_FFEF);

        applyStimulus(2'd0, 1'b0, 32'd0);
        applyStimulus(2'd0, 1'b0, 32'd0);
        applyStimulus(2'd3, 1'b0, 32'd0);
        checkOutput("stall3_p1", 1'b1, 32'h1C, 32'hFFFF_FFE3);
        applyStimulus(2'd3, 1'b0, 32'd0);
        checkOutput("stall3_p2", 1'b1, 32'h1C, 32'hFFFF_FFE3);
        applyStimulus(2'd3, 1'b0, 32'd0);
        checkOutput("stall3_p3", 1'b1, 32'h1C, 32'hFFFF_FFE3);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("stall3_p4", 1'b1, 32'h1C, 32'hFFFF_FFE3);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("stall3_resume", 1'b1, 32'h20, 32'hFFFF_FFDF);

        repeat (6) applyStimulus(2'd0, 1'b0, 32'd0);
        applyStimulus(2'd0, 1'b1, 32'h0000_0103);
        checkOutput("pre_branch", 1'b1, 32'h3C, 32'hFFFF_FFC3);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("branch_bubble", 1'b0, 32'h0, NOP_INSTR);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("branch_target", 1'b1, 32'h100, 32'hFFFF_FEFF);

        applyStimulus(2'd2, 1'b1, 32'h0000_0200);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("brstall_bubble", 1'b0, 32'h0, NOP_INSTR);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("brstall_target", 1'b1, 32'h200, 32'hFFFF_FDFF);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("brstall_noreplay", 1'b1, 32'h204, 32'hFFFF_FDFB);

        applyStimulus(2'd0, 1'b1, 32'hFFFF_FFF9);
        applyStimulus(2'd0, 1'b0, 32'd0);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("wrap_f8", 1'b1, 32'hFFFF_FFF8, 32'h0000_0007);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("wrap_fc", 1'b1, 32'hFFFF_FFFC, 32'h0000_0003);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("wrap_0", 1'b1, 32'h0, 32'hFFFF_FFFF);

        applyStimulus(2'd3, 1'b0, 32'd0);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("hold_before_rst", 1'b1, 32'h4, 32'hFFFF_FFFB);
        i_rst_n = 1'b0;
        #1;
        checkReset("async_reset");
        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b1;
        checkOutput("post_rst_bubble", 1'b0, RESET_PC, NOP_INSTR);
        applyStimulus(2'd0, 1'b0, 32'd0);
        checkOutput("post_rst_run", 1'b1, RESET_PC, 32'hFFFF_FFFF);

        for (int i = 0; i < 3000; i++) begin
            logic [1:0] st;
            logic       br;
            st = ($urandom_range(0, 15) < 11) ? 2'd0 : 2'($urandom_range(1, 3));
            br = ($urandom_range(0, 9) == 0);
            applyStimulus(st, br, $urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2;
                i_rst_n = 1'b0;
                @(negedge i_clk);
                #1;
                i_rst_n = 1'b1;
            end
        end

        applyStimulus(2'd0, 1'b0, 32'd0);
        @(negedge i_clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
